dmem_lsu: RTL and testbench

Load/store unit between the pipeline's memory stage and the data-memory bus. It takes the M-stage address, store data and access type, and produces word-aligned bus transactions with byte enables. It returns aligned, sign- or zero-extended load data as `readDataM` and holds the pipeline stalled until the bus acknowledges.

---
 rtl/dmem_lsu.sv | 205 ++++++++++++++++++++
 tb/tb_dmem_lsu.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_lsu.sv
// dmem_lsu: load/store unit between the M stage and the data-memory bus.
// Turns an M-stage access into one word-aligned bus transaction with byte
// enables, formats returned load data and stalls the pipeline until the bus
// acknowledges.
// Optional feature: define DMEM_LSU_TIMEOUT_EN to abort a REQ that sees no
// bus_ack within TIMEOUT_CYCLES cycles (bus_err pulse, rdata forced to 0).
module dmem_lsu #(
   parameter int unsigned TIMEOUT_CYCLES = 256
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_req,
   input  logic        mem_we,
   input  logic [1:0]  mem_size,
   input  logic        mem_sign,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        stall,
   output logic        addr_err,
   output logic        bus_err,
   output logic        bus_req,
   output logic        bus_we,
   output logic [3:0]  bus_be,
   output logic [31:0] bus_addr,
   output logic [31:0] bus_wdata,
   input  logic        bus_ack,
   input  logic [31:0] bus_rdata
);

   typedef enum logic [1:0] {StIdle, StReq, StResp} state_e;

   state_e      state_q, state_d;
   logic        bus_we_q, bus_we_d;
   logic [3:0]  bus_be_q, bus_be_d;
   logic [31:0] bus_addr_q, bus_addr_d;
   logic [31:0] bus_wdata_q, bus_wdata_d;
   logic [1:0]  off_q, off_d;
   logic [1:0]  size_q, size_d;
   logic        sign_q, sign_d;
   logic [31:0] rdata_q, rdata_d;
   logic        bus_err_q, bus_err_d;

   logic        is_half, is_word;
   logic        start;
   logic        expire;
   logic [3:0]  be_new;
   logic [31:0] wdata_new;
   logic [31:0] load_fmt;

   // Aligned load data: pick the addressed lane(s), then sign/zero extend
   function automatic logic [31:0] fmt_load(input logic [31:0] word, input logic [1:0] off,
                                            input logic [1:0] size, input logic sgn);
      logic [7:0]  b;
      logic [15:0] h;
      logic [31:0] res;
      b = word[{off, 3'b000} +: 8];
      h = off[1] ? word[31:16] : word[15:0];
      case (size)
         2'b00:   res = {{24{sgn & b[7]}}, b};
         2'b01:   res = {{16{sgn & h[15]}}, h};
         default: res = word;
      endcase
      return res;
   endfunction

   // Decode the incoming access: misalignment, byte enables and lane-replicated store data
   always_comb begin
      is_half  = (mem_size == 2'b01);
      is_word  = mem_size[1];
      addr_err = mem_req & ((is_half & addr[0]) | (is_word & (addr[1:0] != 2'b00)));
      start    = (state_q == StIdle) & mem_req & ~addr_err;
      case (mem_size)
         2'b00: begin
            be_new    = 4'b0001 << addr[1:0];
            wdata_new = {4{wdata[7:0]}};
         end
         2'b01: begin
            be_new    = addr[1] ? 4'b1100 : 4'b0011;
            wdata_new = {2{wdata[15:0]}};
         end
         default: begin
            be_new    = 4'b1111;
            wdata_new = wdata;
         end
      endcase
      load_fmt = fmt_load(bus_rdata, off_q, size_q, sign_q);
   end

`ifdef DMEM_LSU_TIMEOUT_EN
   localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

   logic [CntW-1:0] cnt_q, cnt_d;

   // Count REQ cycles; expiry fires on the TIMEOUT_CYCLES-th REQ cycle
   always_comb begin
      cnt_d  = cnt_q;
      expire = 1'b0;
      if (start) begin
         cnt_d = '0;
      end else if (state_q == StReq) begin
         cnt_d  = cnt_q + CntW'(1);
         expire = (cnt_d == CntW'(TIMEOUT_CYCLES));
      end
   end

   // Timeout counter register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end
`else
   logic unused_timeout_cfg;

   assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
   assign expire             = 1'b0;
`endif

   // Next-state logic: latch the transaction on IDLE->REQ, capture load data on ack
   always_comb begin
      state_d     = state_q;
      bus_we_d    = bus_we_q;
      bus_be_d    = bus_be_q;
      bus_addr_d  = bus_addr_q;
      bus_wdata_d = bus_wdata_q;
      off_d       = off_q;
      size_d      = size_q;
      sign_d      = sign_q;
      rdata_d     = rdata_q;
      bus_err_d   = 1'b0;
      case (state_q)
         StIdle: begin
            if (start) begin
               state_d     = StReq;
               bus_we_d    = mem_we;
               bus_be_d    = be_new;
               bus_addr_d  = {addr[31:2], 2'b00};
               bus_wdata_d = wdata_new;
               off_d       = addr[1:0];
               size_d      = mem_size;
               sign_d      = mem_sign;
            end
         end
         StReq: begin
            // An ack coinciding with expiry completes normally
            if (bus_ack) begin
               state_d = StResp;
               if (!bus_we_q) begin
                  rdata_d = load_fmt;
               end
            end else if (expire) begin
               state_d   = StResp;
               bus_err_d = 1'b1;
               rdata_d   = '0;
            end
         end
         // A request still visible here belongs to the completing instruction
         StResp:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // State and transaction registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= StIdle;
         bus_we_q    <= 1'b0;
         bus_be_q    <= 4'b0000;
         bus_addr_q  <= '0;
         bus_wdata_q <= '0;
         off_q       <= 2'b00;
         size_q      <= 2'b00;
         sign_q      <= 1'b0;
         rdata_q     <= '0;
         bus_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         bus_we_q    <= bus_we_d;
         bus_be_q    <= bus_be_d;
         bus_addr_q  <= bus_addr_d;
         bus_wdata_q <= bus_wdata_d;
         off_q       <= off_d;
         size_q      <= size_d;
         sign_q      <= sign_d;
         rdata_q     <= rdata_d;
         bus_err_q   <= bus_err_d;
      end
   end

   // Outputs; bus_req decodes the state flop so reset drops it asynchronously
   always_comb begin
      bus_req   = (state_q == StReq);
      stall     = start | (state_q == StReq);
      bus_we    = bus_we_q;
      bus_be    = bus_be_q;
      bus_addr  = bus_addr_q;
      bus_wdata = bus_wdata_q;
      rdata     = rdata_q;
      bus_err   = bus_err_q;
   end

endmodule

// File: tb/tb_dmem_lsu.sv
// Directed self-checking bench for dmem_lsu.
// Timeout checks run only when DMEM_LSU_TIMEOUT_EN is defined (TIMEOUT_CYCLES=4).
module tb_dmem_lsu;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        mem_req = 1'b0;
   logic        mem_we = 1'b0;
   logic [1:0]  mem_size = 2'b00;
   logic        mem_sign = 1'b0;
   logic [31:0] addr = '0;
   logic [31:0] wdata = '0;
   logic [31:0] rdata;
   logic        stall;
   logic        addr_err;
   logic        bus_err;
   logic        bus_req;
   logic        bus_we;
   logic [3:0]  bus_be;
   logic [31:0] bus_addr;
   logic [31:0] bus_wdata;
   logic        bus_ack = 1'b0;
   logic [31:0] bus_rdata = '0;

   int checks = 0;
   int errors = 0;

   dmem_lsu #(.TIMEOUT_CYCLES(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .mem_size  (mem_size),
      .mem_sign  (mem_sign),
      .addr      (addr),
      .wdata     (wdata),
      .rdata     (rdata),
      .stall     (stall),
      .addr_err  (addr_err),
      .bus_err   (bus_err),
      .bus_req   (bus_req),
      .bus_we    (bus_we),
      .bus_be    (bus_be),
      .bus_addr  (bus_addr),
      .bus_wdata (bus_wdata),
      .bus_ack   (bus_ack),
      .bus_rdata (bus_rdata)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One access starting in the current IDLE cycle; waits = extra REQ cycles before ack
   task automatic do_access(input string tag, input logic we, input logic [1:0] size,
                            input logic sgn, input logic [31:0] a, input logic [31:0] wd,
                            input logic [31:0] rd, input int waits, input logic [3:0] exp_be,
                            input logic [31:0] exp_addr, input logic [31:0] exp_wdata,
                            input logic [31:0] exp_rdata);
      mem_req  = 1'b1;
      mem_we   = we;
      mem_size = size;
      mem_sign = sgn;
      addr     = a;
      wdata    = wd;
      bus_ack  = 1'b0;
      #1;
      chk({tag, "_idle_stall"}, 32'(stall), 32'd1);
      chk({tag, "_idle_req"}, 32'(bus_req), 32'd0);
      tick();
      // Disturb the inputs: the latched bus fields must not follow them
      addr  = a ^ 32'h0F0F_0F00;
      wdata = ~wd;
      for (int i = 0; i <= waits; i++) begin
         chk({tag, "_req"}, 32'(bus_req), 32'd1);
         chk({tag, "_req_stall"}, 32'(stall), 32'd1);
         chk({tag, "_be"}, 32'(bus_be), 32'(exp_be));
         chk({tag, "_addr"}, bus_addr, exp_addr);
         chk({tag, "_we"}, 32'(bus_we), 32'(we));
         if (we) chk({tag, "_wdata"}, bus_wdata, exp_wdata);
         if (i == waits) begin
            bus_ack   = 1'b1;
            bus_rdata = rd;
         end
         tick();
      end
      // RESP: a late ack with different data must be ignored
      bus_rdata = ~rd;
      #1;
      chk({tag, "_resp_req"}, 32'(bus_req), 32'd0);
      chk({tag, "_resp_stall"}, 32'(stall), 32'd0);
      chk({tag, "_resp_err"}, 32'(bus_err), 32'd0);
      chk({tag, "_rdata"}, rdata, exp_rdata);
      tick();
      bus_ack = 1'b0;
      mem_req = 1'b0;
      #1;
      chk({tag, "_post_req"}, 32'(bus_req), 32'd0);
      chk({tag, "_post_rdata"}, rdata, exp_rdata);
   endtask

   initial begin
      // Reset values
      #12;
      chk("rst_req", 32'(bus_req), 32'd0);
      chk("rst_we", 32'(bus_we), 32'd0);
      chk("rst_be", 32'(bus_be), 32'd0);
      chk("rst_addr", bus_addr, 32'd0);
      chk("rst_wdata", bus_wdata, 32'd0);
      chk("rst_rdata", rdata, 32'd0);
      chk("rst_err", 32'(bus_err), 32'd0);
      chk("rst_stall", 32'(stall), 32'd0);
      @(negedge clk);
      rst = 1'b1;
      tick();

      // Loads
      do_access("ldw", 1'b0, 2'b10, 1'b0, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF, 1, 4'b1111,
                32'h0000_0100, 32'h0, 32'hDEAD_BEEF);
      do_access("ldb_s", 1'b0, 2'b00, 1'b1, 32'h0000_0103, 32'h0, 32'h8012_3456, 0, 4'b1000,
                32'h0000_0100, 32'h0, 32'hFFFF_FF80);
      do_access("ldb_u", 1'b0, 2'b00, 1'b0, 32'h0000_0103, 32'h0, 32'h8012_3456, 0, 4'b1000,
                32'h0000_0100, 32'h0, 32'h0000_0080);
      do_access("ldh_s", 1'b0, 2'b01, 1'b1, 32'h0000_0002, 32'h0, 32'h8001_7FFF, 0, 4'b1100,
                32'h0000_0000, 32'h0, 32'hFFFF_8001);
      do_access("ldh_u", 1'b0, 2'b01, 1'b0, 32'h0000_0000, 32'h0, 32'h8001_7FFF, 0, 4'b0011,
                32'h0000_0000, 32'h0, 32'h0000_7FFF);
      do_access("ldb1_s", 1'b0, 2'b00, 1'b1, 32'h0000_0101, 32'h0, 32'h0000_AB00, 0, 4'b0010,
                32'h0000_0100, 32'h0, 32'hFFFF_FFAB);
      do_access("ld_sz3", 1'b0, 2'b11, 1'b1, 32'h0000_0104, 32'h0, 32'h1234_5678, 3, 4'b1111,
                32'h0000_0104, 32'h0, 32'h1234_5678);

      // Stores: rdata keeps the last load value
      do_access("sth", 1'b1, 2'b01, 1'b0, 32'h0000_0202, 32'h1234_ABCD, 32'hFFFF_FFFF, 0,
                4'b1100, 32'h0000_0200, 32'hABCD_ABCD, 32'h1234_5678);
      do_access("stb", 1'b1, 2'b00, 1'b0, 32'h0000_0301, 32'h0000_00EE, 32'hFFFF_FFFF, 2,
                4'b0010, 32'h0000_0300, 32'hEEEE_EEEE, 32'h1234_5678);
      do_access("stw", 1'b1, 2'b10, 1'b0, 32'h0000_0400, 32'hCAFE_F00D, 32'hFFFF_FFFF, 0,
                4'b1111, 32'h0000_0400, 32'hCAFE_F00D, 32'h1234_5678);

      // Misaligned accesses: flag, no stall, no bus transaction
      mem_req  = 1'b1;
      mem_we   = 1'b0;
      mem_size = 2'b10;
      addr     = 32'h0000_0101;
      #1;
      chk("mis_w_err", 32'(addr_err), 32'd1);
      chk("mis_w_stall", 32'(stall), 32'd0);
      tick();
      chk("mis_w_req1", 32'(bus_req), 32'd0);
      tick();
      chk("mis_w_req2", 32'(bus_req), 32'd0);
      mem_size = 2'b01;
      addr     = 32'h0000_0003;
      #1;
      chk("mis_h_err", 32'(addr_err), 32'd1);
      chk("mis_h_stall", 32'(stall), 32'd0);
      addr = 32'h0000_0002;
      #1;
      chk("al_h_err", 32'(addr_err), 32'd0);
      mem_size = 2'b00;
      addr     = 32'h0000_0003;
      #1;
      chk("al_b_err", 32'(addr_err), 32'd0);
      mem_req  = 1'b0;
      mem_size = 2'b10;
      addr     = 32'h0000_0101;
      #1;
      chk("noreq_err", 32'(addr_err), 32'd0);
      tick();
      chk("mis_idle_req", 32'(bus_req), 32'd0);

`ifdef DMEM_LSU_TIMEOUT_EN
      // No ack: four REQ cycles, then RESP with bus_err and rdata cleared
      mem_req  = 1'b1;
      mem_we   = 1'b0;
      mem_size = 2'b10;
      addr     = 32'h0000_0700;
      tick();
      for (int i = 0; i < 4; i++) begin
         chk("to_req", 32'(bus_req), 32'd1);
         chk("to_err_req", 32'(bus_err), 32'd0);
         tick();
      end
      chk("to_resp_req", 32'(bus_req), 32'd0);
      chk("to_resp_err", 32'(bus_err), 32'd1);
      chk("to_rdata", rdata, 32'd0);
      chk("to_stall", 32'(stall), 32'd0);
      tick();
      mem_req = 1'b0;
      #1;
      chk("to_idle_err", 32'(bus_err), 32'd0);
      chk("to_idle_req", 32'(bus_req), 32'd0);
`endif

      // Reset pulse in the middle of REQ; later ack ignored
      do_access("ldw2", 1'b0, 2'b10, 1'b0, 32'h0000_0500, 32'h0, 32'h1111_2222, 0, 4'b1111,
                32'h0000_0500, 32'h0, 32'h1111_2222);
      mem_req  = 1'b1;
      mem_we   = 1'b0;
      mem_size = 2'b10;
      addr     = 32'h0000_0600;
      tick();
      chk("rr_req_before", 32'(bus_req), 32'd1);
      #2;
      rst     = 1'b0;
      mem_req = 1'b0;
      #1;
      chk("rr_req_drop", 32'(bus_req), 32'd0);
      chk("rr_stall", 32'(stall), 32'd0);
      chk("rr_rdata", rdata, 32'd0);
      chk("rr_be", 32'(bus_be), 32'd0);
      @(negedge clk);
      rst       = 1'b1;
      bus_ack   = 1'b1;
      bus_rdata = 32'hFFFF_FFFF;
      tick();
      chk("rr_ack_req", 32'(bus_req), 32'd0);
      chk("rr_ack_rdata", rdata, 32'd0);
      tick();
      chk("rr_ack_rdata2", rdata, 32'd0);
      chk("rr_ack_stall", 32'(stall), 32'd0);
      bus_ack = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
